// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronized sources, PENDING/ENABLE/CLAIM registers behind a sel/busy handshake.
// Define IRQ_CTRL_EDGE_EN for edge-latched pending bits; the default build tracks the source level.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               sel,
  input  logic               write_en,
  input  logic [1:0]         addr,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               busy,
  output logic               fault,
  output logic               ext_int
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0] sync1_q, sync1_d;
  logic [NUM_SRC-1:0] sync2_q, sync2_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic               inserv_q, inserv_d;
  logic [4:0]         inserv_id_q, inserv_id_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               fault_q, fault_d;
  logic               ext_int_q, ext_int_d;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic [4:0]         claim_idx;
  logic [31:0]        claim_id;
  logic               claim_fire;
  logic [31:0]        pending_ext;
  logic [31:0]        enable_ext;

  always_comb begin
    sync1_d = irq_src;
    sync2_d = sync1_q;
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;

  // A fresh rising edge wins over a claim clearing the same bit.
  always_comb begin
    src_prev_d = sync2_q;
    pending_d  = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim_fire && (claim_idx == 5'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (sync2_q[i] && !src_prev_q[i]) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      src_prev_q <= src_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = sync2_q;
`endif

  assign eligible    = pending & enable_q;
  assign pending_ext = {{(32-NUM_SRC){1'b0}}, pending};
  assign enable_ext  = {{(32-NUM_SRC){1'b0}}, enable_q};

  // Lowest eligible index has priority.
  always_comb begin
    claim_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        claim_idx = 5'(i);
      end
    end
  end

  assign claim_id   = {27'd0, claim_idx + 5'd1};
  assign claim_fire = (state_q == ACCESS) && (addr == ADDR_CLAIM) && !write_en &&
                      !inserv_q && (|eligible);

  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    inserv_d    = inserv_q;
    inserv_id_d = inserv_id_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        busy = sel;
        if (sel) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy        = 1'b1;
        state_d     = DONE;
        read_data_d = '0;
        fault_d     = 1'b0;
        case (addr)
          ADDR_PENDING: begin
            if (!write_en) begin
              read_data_d = pending_ext;
            end
          end
          ADDR_ENABLE: begin
            if (write_en) begin
              enable_d = write_data[NUM_SRC-1:0];
            end else begin
              read_data_d = enable_ext;
            end
          end
          ADDR_CLAIM: begin
            if (write_en) begin
              if (inserv_q && (write_data == {27'd0, inserv_id_q})) begin
                inserv_d    = 1'b0;
                inserv_id_d = '0;
              end
            end else if (claim_fire) begin
              read_data_d = claim_id;
              inserv_d    = 1'b1;
              inserv_id_d = claim_id[4:0];
            end
          end
          default: begin
            fault_d = 1'b1;
          end
        endcase
      end
      DONE: begin
        if (!sel) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ext_int_d = (|eligible) && !inserv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      enable_q    <= '0;
      inserv_q    <= 1'b0;
      inserv_id_q <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
      ext_int_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      enable_q    <= enable_d;
      inserv_q    <= inserv_d;
      inserv_id_q <= inserv_id_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      ext_int_q   <= ext_int_d;
    end
  end

  assign read_data = read_data_q;
  assign fault     = fault_q;
  assign ext_int   = ext_int_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register vector table plus claim, reset and level/edge sequences.
module tb_irq_ctrl;

  localparam int NUM_SRC = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_SRC-1:0] irq_src;
  logic               sel;
  logic               write_en;
  logic [1:0]         addr;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               busy;
  logic               fault;
  logic               ext_int;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .sel        (sel),
    .write_en   (write_en),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy),
    .fault      (fault),
    .ext_int    (ext_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  // One handshake; the busy-low latency is checked on every access.
  task automatic do_access(input logic we, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic flt);
    int cyc;
    @(negedge clk);
    sel = 1'b1; write_en = we; addr = a; write_data = wd;
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!busy) break;
    end
    check("latency", 32'(cyc), 32'd2);
    rd  = read_data;
    flt = fault;
    sel = 1'b0; write_en = 1'b0;
    @(posedge clk);
  endtask

  task automatic acc_check(input string nm, input logic we, input logic [1:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [31:0] rd;
    logic        flt;
    do_access(we, a, wd, rd, flt);
    check(nm, rd, exp_rd);
  endtask

  task automatic wait_ext(input logic exp, input string nm);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ext_int === exp) break;
    end
    check(nm, 32'(ext_int), 32'(exp));
  endtask

  task automatic settle_ext(input logic exp, input string nm);
    repeat (3) @(negedge clk);
    check(nm, 32'(ext_int), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; irq_src = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        flt;

    reset_n = 1'b0; sel = 1'b0; write_en = 1'b0; addr = '0; write_data = '0; irq_src = '0;

    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0,  1'b0};
    vecs[1]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0,  1'b0};
    vecs[2]  = '{1'b0, 2'd1, 32'h0,        32'hFF, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 32'h0000_0005, 32'h0,  1'b0};
    vecs[4]  = '{1'b0, 2'd1, 32'h0,        32'h05, 1'b0};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,        32'h0,  1'b1};
    vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0,  1'b1};
    vecs[7]  = '{1'b0, 2'd1, 32'h0,        32'h05, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 32'h0000_00FF, 32'h0,  1'b0};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        32'h0,  1'b0};
    vecs[10] = '{1'b0, 2'd2, 32'h0,        32'h0,  1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),    32'd0);
    check("rst_read_data", read_data,    32'd0);
    check("rst_fault",     32'(fault),   32'd0);
    check("rst_ext_int",   32'(ext_int), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].we, vecs[i].a, vecs[i].wd, rd, flt);
      check($sformatf("vec%0d_rd", i),    rd,       vecs[i].exp_rd);
      check($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].exp_fault));
    end
    check("vec_ext_int_idle", 32'(ext_int), 32'd0);

    // ENABLE=0x05, source 2 raised then dropped.
    irq_src = 8'h04;
    wait_ext(1'b1, "src2_ext_int");
    acc_check("src2_pending_held", 1'b0, 2'd0, 32'h0, 32'h04);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
`ifdef IRQ_CTRL_EDGE_EN
    acc_check("src2_pending_latched", 1'b0, 2'd0, 32'h0, 32'h04);
    acc_check("src2_claim",           1'b0, 2'd2, 32'h0, 32'd3);
    acc_check("src2_complete",        1'b1, 2'd2, 32'd3, 32'h0);
    acc_check("src2_pending_cleared", 1'b0, 2'd0, 32'h0, 32'h00);
`else
    acc_check("src2_pending_level",   1'b0, 2'd0, 32'h0, 32'h00);
    acc_check("src2_claim_none",      1'b0, 2'd2, 32'h0, 32'd0);
`endif
    settle_ext(1'b0, "src2_ext_int_after");

    // Sources 1 and 2, claim ordering and completion.
    do_reset();
    acc_check("c_en_write", 1'b1, 2'd1, 32'h06, 32'h0);
    irq_src = 8'h06;
    wait_ext(1'b1, "c_ext_int_up");
    acc_check("c_claim1", 1'b0, 2'd2, 32'h0, 32'd2);
    settle_ext(1'b0, "c_ext_int_inserv");
    acc_check("c_claim2", 1'b0, 2'd2, 32'h0, 32'd0);
    acc_check("c_wrong_complete", 1'b1, 2'd2, 32'd5, 32'h0);
    settle_ext(1'b0, "c_ext_int_after_wrong");
    acc_check("c_claim_still_busy", 1'b0, 2'd2, 32'h0, 32'd0);
    acc_check("c_complete", 1'b1, 2'd2, 32'd2, 32'h0);
    settle_ext(1'b1, "c_ext_int_back");
`ifdef IRQ_CTRL_EDGE_EN
    acc_check("c_claim_next", 1'b0, 2'd2, 32'h0, 32'd3);
`else
    acc_check("c_claim_next", 1'b0, 2'd2, 32'h0, 32'd2);
`endif

    // Reset asserted while a CLAIM read is in ACCESS.
    do_reset();
    acc_check("r_en_write", 1'b1, 2'd1, 32'h01, 32'h0);
    irq_src = 8'h01;
    wait_ext(1'b1, "r_ext_int_up");
    acc_check("r_en_read", 1'b0, 2'd1, 32'h0, 32'h01);
    @(negedge clk);
    sel = 1'b1; write_en = 1'b0; addr = 2'd2;
    @(posedge clk);
    #1;
    check("r_busy_access", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("r_busy_eq_sel",  32'(busy),    32'd1);
    check("r_read_data",    read_data,    32'd0);
    check("r_fault",        32'(fault),   32'd0);
    check("r_ext_int",      32'(ext_int), 32'd0);
    sel = 1'b0;
    #1;
    check("r_busy_sel_low", 32'(busy),    32'd0);
    irq_src = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    acc_check("r_en_cleared", 1'b0, 2'd1, 32'h0, 32'h0);
    acc_check("r_pend_cleared", 1'b0, 2'd0, 32'h0, 32'h0);
    acc_check("r_en_write2", 1'b1, 2'd1, 32'h01, 32'h0);
    irq_src = 8'h01;
    wait_ext(1'b1, "r_ext_int_free");
    acc_check("r_claim_free", 1'b0, 2'd2, 32'h0, 32'd1);

    // Held source 0 through a full claim/complete cycle.
    do_reset();
    acc_check("l_en_write", 1'b1, 2'd1, 32'h01, 32'h0);
    irq_src = 8'h01;
    wait_ext(1'b1, "l_ext_int_up");
    acc_check("l_claim", 1'b0, 2'd2, 32'h0, 32'd1);
    settle_ext(1'b0, "l_ext_int_inserv");
    acc_check("l_complete", 1'b1, 2'd2, 32'd1, 32'h0);
`ifdef IRQ_CTRL_EDGE_EN
    acc_check("l_pending", 1'b0, 2'd0, 32'h0, 32'h00);
    settle_ext(1'b0, "l_ext_int_after");
`else
    acc_check("l_pending", 1'b0, 2'd0, 32'h0, 32'h01);
    wait_ext(1'b1, "l_ext_int_after");
`endif

    // Disabling a pending source keeps its pending bit.
    acc_check("d_disable", 1'b1, 2'd1, 32'h00, 32'h0);
`ifdef IRQ_CTRL_EDGE_EN
    irq_src = 8'h00;
    repeat (3) @(negedge clk);
    irq_src = 8'h01;
    repeat (4) @(negedge clk);
`endif
    acc_check("d_pending_kept", 1'b0, 2'd0, 32'h0, 32'h01);
    settle_ext(1'b0, "d_ext_int_disabled");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
